// File: rtl/radar_chirp_framer.sv
// Ping-pong chirp framer: gathers FRAME_LEN streaming ADC samples per chirp into one of
// two banks and presents the oldest complete bank to the range processor, with drop/short statistics.
module radar_chirp_framer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 128,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    chirp_start,
    output logic [SAMPLE_WIDTH-1:0] frame_data [0:FRAME_LEN-1],
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    dropped_chirps,
    output logic [CNT_WIDTH-1:0]    short_chirps,
    output logic [CNT_WIDTH-1:0]    frames_out
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {WR_WAIT, WR_FILL, WR_DROP} wr_state_t;

    wr_state_t               state_q;
    logic [IDX_W-1:0]        wr_idx_q;
    logic                    wr_bank_q;
    logic                    rd_bank_q;
    logic [1:0]              full_q;
    logic [1:0]              full_d;
    logic                    overflow_q;
    logic [CNT_WIDTH-1:0]    dropped_q;
    logic [CNT_WIDTH-1:0]    short_q;
    logic [CNT_WIDTH-1:0]    frames_q;
    logic [SAMPLE_WIDTH-1:0] bank0_q [0:FRAME_LEN-1];
    logic [SAMPLE_WIDTH-1:0] bank1_q [0:FRAME_LEN-1];

    logic             start;
    logic             handshake;
    logic             complete;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;

    assign start     = sample_valid & chirp_start;
    assign handshake = full_q[rd_bank_q] & frame_ready;

    // Write strobe/address decode; a chirp_start inside FILL restarts the same bank at index 0.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = wr_idx_q;
        complete = 1'b0;
        case (state_q)
            WR_FILL: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (chirp_start) begin
                        wr_addr = '0;
                    end else begin
                        complete = (wr_idx_q == LAST_IDX);
                    end
                end
            end
            default: begin
                if (start && !full_q[wr_bank_q]) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                end
            end
        endcase
    end

    // Completion and handshake always target different banks, so both updates apply.
    always_comb begin
        full_d = full_q;
        if (handshake) full_d[rd_bank_q] = 1'b0;
        if (complete)  full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WR_WAIT;
            wr_idx_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            short_q    <= '0;
            frames_q   <= '0;
        end else begin
            full_q <= full_d;
            if (handshake) begin
                rd_bank_q <= ~rd_bank_q;
                frames_q  <= frames_q + CNT_WIDTH'(1);
            end
            case (state_q)
                WR_FILL: begin
                    if (sample_valid) begin
                        if (chirp_start) begin
                            wr_idx_q <= IDX_W'(1);
                            if (short_q != '1) short_q <= short_q + CNT_WIDTH'(1);
                        end else if (complete) begin
                            wr_idx_q  <= '0;
                            wr_bank_q <= ~wr_bank_q;
                            state_q   <= WR_WAIT;
                        end else begin
                            wr_idx_q <= wr_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        if (!full_q[wr_bank_q]) begin
                            wr_idx_q <= IDX_W'(1);
                            state_q  <= WR_FILL;
                        end else begin
                            overflow_q <= 1'b1;
                            state_q    <= WR_DROP;
                            if (dropped_q != '1) dropped_q <= dropped_q + CNT_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Sample storage carries no reset; contents are only meaningful once a bank is full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank_q) bank1_q[wr_addr] <= sample_in;
            else           bank0_q[wr_addr] <= sample_in;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < FRAME_LEN; i++) begin
            frame_data[i] = rd_bank_q ? bank1_q[i] : bank0_q[i];
        end
    end

    assign frame_valid    = full_q[rd_bank_q];
    assign overflow       = overflow_q;
    assign dropped_chirps = dropped_q;
    assign short_chirps   = short_q;
    assign frames_out     = frames_q;

endmodule

// File: tb/tb_radar_chirp_framer.sv
// Self-checking bench for radar_chirp_framer: directed scenarios plus randomized traffic
// compared against a frame-queue reference model.
`timescale 1ns/1ps
module tb_radar_chirp_framer;
    localparam int SW   = 16;
    localparam int FL   = 128;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          chirp_start;
    logic [SW-1:0] frame_data [0:FL-1];
    logic          frame_valid;
    logic          frame_ready;
    logic          overflow;
    logic [CW-1:0] dropped_chirps;
    logic [CW-1:0] short_chirps;
    logic [CW-1:0] frames_out;

    int checks = 0;
    int errors = 0;

    radar_chirp_framer #(
        .SAMPLE_WIDTH(SW),
        .FRAME_LEN(FL),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .chirp_start(chirp_start),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overflow(overflow),
        .dropped_chirps(dropped_chirps),
        .short_chirps(short_chirps),
        .frames_out(frames_out)
    );

    always #5 clk = ~clk;

    // Reference model: ordered store of up to two completed frames plus the chirp being gathered.
    logic [SW-1:0] m_fr   [0:1][0:FL-1];
    logic [SW-1:0] m_part [0:FL-1];
    int m_head, m_cnt, m_len, m_mode, m_drop, m_short, m_out;
    bit m_ovf;

    task automatic model_reset();
        m_head = 0; m_cnt = 0; m_len = 0; m_mode = 0;
        m_drop = 0; m_short = 0; m_out = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic v, input logic s, input logic [SW-1:0] d, input logic r);
        int sz;
        bit hs, done;
        sz   = m_cnt;
        hs   = (sz > 0) && r;
        done = 0;
        if (v) begin
            if (s) begin
                if (m_mode == 1) begin
                    if (m_short < CMAX) m_short++;
                    m_part[0] = d; m_len = 1;
                end else if (sz < 2) begin
                    m_mode = 1; m_part[0] = d; m_len = 1;
                end else begin
                    m_mode = 2; m_ovf = 1;
                    if (m_drop < CMAX) m_drop++;
                end
            end else if (m_mode == 1) begin
                m_part[m_len] = d;
                m_len++;
                if (m_len == FL) begin done = 1; m_mode = 0; m_len = 0; end
            end
        end
        if (hs) begin m_head = 1 - m_head; m_cnt--; m_out++; end
        if (done) begin
            for (int i = 0; i < FL; i++) m_fr[(m_head + m_cnt) % 2][i] = m_part[i];
            m_cnt++;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [SW-1:0] d, input logic r);
        sample_valid = v; chirp_start = s; sample_in = d; frame_ready = r;
        @(posedge clk);
        model_edge(v, s, d, r);
        #1;
    endtask

    task automatic send_chirp(input logic [SW-1:0] base, input int stride, input logic r);
        for (int i = 0; i < FL; i++) step(1'b1, i == 0, base + SW'(stride * i), r);
    endtask

    function automatic int frame_diff(input logic [SW-1:0] base, input int stride);
        int bad = 0;
        for (int i = 0; i < FL; i++)
            if (frame_data[i] !== base + SW'(stride * i)) bad++;
        return bad;
    endfunction

    task automatic apply_reset();
        sample_valid = 0; chirp_start = 0; sample_in = '0; frame_ready = 0;
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if ({dropped_chirps, short_chirps, frames_out} !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", dropped_chirps, short_chirps, frames_out);
        end
    endtask

    task automatic test_single();
        int bad;
        apply_reset();
        for (int i = 0; i < FL - 1; i++) step(1'b1, i == 0, SW'(i), 1'b0);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", frame_valid); end
        step(1'b1, 1'b0, SW'(FL - 1), 1'b0);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", frame_valid); end
        bad = frame_diff('0, 1);
        checks++; if (bad != 0) begin errors++; $display("FAIL single_data: %0d words wrong, want 0", bad); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
        bad = frame_diff('0, 1);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin
            errors++; $display("FAIL single_hold: valid %b bad %0d want 1/0", frame_valid, bad);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        checks++; if (frames_out !== CW'(1) || frame_valid !== 1'b0) begin
            errors++; $display("FAIL single_handshake: frames_out %0d valid %b want 1/0", frames_out, frame_valid);
        end
    endtask

    task automatic test_pingpong();
        int bad;
        apply_reset();
        send_chirp(16'h1000, 1, 1'b0);
        send_chirp(16'h2000, 1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, i == 0, 16'h3000 + SW'(i), 1'b0);
        checks++; if (dropped_chirps !== CW'(1) || overflow !== 1'b1) begin
            errors++; $display("FAIL pingpong_drop: dropped %0d overflow %b want 1/1", dropped_chirps, overflow);
        end
        bad = frame_diff(16'h1000, 1);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin errors++; $display("FAIL pingpong_A: valid %b bad %0d want 1/0", frame_valid, bad); end
        step(1'b0, 1'b0, '0, 1'b1);
        bad = frame_diff(16'h2000, 1);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin errors++; $display("FAIL pingpong_B: valid %b bad %0d want 1/0", frame_valid, bad); end
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        checks++; if (frames_out !== CW'(2) || frame_valid !== 1'b0) begin
            errors++; $display("FAIL pingpong_count: frames_out %0d valid %b want 2/0", frames_out, frame_valid);
        end
    endtask

    task automatic test_short();
        int bad;
        apply_reset();
        for (int i = 0; i < 50; i++) step(1'b1, i == 0, 16'h5000 + SW'(i), 1'b0);
        send_chirp(16'h0AAA, 0, 1'b0);
        checks++; if (short_chirps !== CW'(1) || dropped_chirps !== '0) begin
            errors++; $display("FAIL short_count: short %0d dropped %0d want 1/0", short_chirps, dropped_chirps);
        end
        bad = frame_diff(16'h0AAA, 0);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin errors++; $display("FAIL short_data: valid %b bad %0d want 1/0", frame_valid, bad); end
    endtask

    task automatic test_free_same_cycle();
        int bad;
        apply_reset();
        send_chirp(16'h1000, 1, 1'b0);
        send_chirp(16'h2000, 1, 1'b0);
        step(1'b1, 1'b1, 16'h7777, 1'b1);
        checks++; if (dropped_chirps !== CW'(1) || frames_out !== CW'(1)) begin
            errors++; $display("FAIL freecycle_drop: dropped %0d frames_out %0d want 1/1", dropped_chirps, frames_out);
        end
        send_chirp(16'h3000, 1, 1'b0);
        bad = frame_diff(16'h2000, 1);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin errors++; $display("FAIL freecycle_B: valid %b bad %0d want 1/0", frame_valid, bad); end
        step(1'b0, 1'b0, '0, 1'b1);
        bad = frame_diff(16'h3000, 1);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin errors++; $display("FAIL freecycle_C: valid %b bad %0d want 1/0", frame_valid, bad); end
        step(1'b0, 1'b0, '0, 1'b1);
        checks++; if (frames_out !== CW'(3) || dropped_chirps !== CW'(1)) begin
            errors++; $display("FAIL freecycle_count: frames_out %0d dropped %0d want 3/1", frames_out, dropped_chirps);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        apply_reset();
        send_chirp(16'h1000, 1, 1'b0);
        send_chirp(16'h2000, 1, 1'b0);
        step(1'b1, 1'b1, 16'h3000, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b1, i == 0, 16'h4000 + SW'(i), 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (frame_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: valid %b overflow %b want 0/0", frame_valid, overflow);
        end
        checks++; if ({dropped_chirps, short_chirps, frames_out} !== '0) begin
            errors++; $display("FAIL midreset_counters: got %0d/%0d/%0d want 0/0/0", dropped_chirps, short_chirps, frames_out);
        end
        sample_valid = 0; chirp_start = 0; frame_ready = 0;
        model_reset();
        #1;
        reset = 1'b0;
        send_chirp(16'h6000, 3, 1'b0);
        bad = frame_diff(16'h6000, 3);
        checks++; if (frame_valid !== 1'b1 || bad != 0) begin errors++; $display("FAIL midreset_data: valid %b bad %0d want 1/0", frame_valid, bad); end
        step(1'b0, 1'b0, '0, 1'b1);
        checks++; if (frames_out !== CW'(1) || short_chirps !== '0) begin
            errors++; $display("FAIL midreset_count: frames_out %0d short %0d want 1/0", frames_out, short_chirps);
        end
    endtask

    task automatic test_streaming();
        int delivered = 0;
        int bad;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < FL; i++) begin
                if (frame_valid === 1'b1) begin
                    bad = frame_diff(SW'(k * 256 - 256), 1);
                    checks++; if (bad != 0) begin errors++; $display("FAIL stream_data%0d: bad %0d want 0", delivered, bad); end
                    delivered++;
                end
                step(1'b1, i == 0, SW'(k * 256 + i), 1'b1);
            end
        end
        if (frame_valid === 1'b1) begin
            bad = frame_diff(SW'(9 * 256), 1);
            checks++; if (bad != 0) begin errors++; $display("FAIL stream_data_last: bad %0d want 0", bad); end
            delivered++;
        end
        step(1'b0, 1'b0, '0, 1'b1);
        checks++; if (frames_out !== CW'(10) || delivered != 10) begin
            errors++; $display("FAIL stream_count: frames_out %0d seen %0d want 10/10", frames_out, delivered);
        end
        checks++; if (overflow !== 1'b0 || dropped_chirps !== '0) begin
            errors++; $display("FAIL stream_drops: overflow %b dropped %0d want 0/0", overflow, dropped_chirps);
        end
    endtask

    task automatic test_random();
        logic v, s, r;
        int bad;
        apply_reset();
        for (int c = 0; c < 6000; c++) begin
            v = ($urandom_range(0, 9) != 0);
            s = v && ((m_mode == 1) ? ($urandom_range(0, 159) == 0) : ($urandom_range(0, 7) == 0));
            r = ((c / 700) % 2 == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
            step(v, s, SW'($urandom), r);
            checks++;
            if (frame_valid !== (m_cnt > 0) || overflow !== m_ovf) begin
                errors++;
                if (errors < 20) $display("FAIL rand_flags@%0d: valid %b overflow %b want %b/%b", c, frame_valid, overflow, m_cnt > 0, m_ovf);
            end
            checks++;
            if (dropped_chirps !== CW'(m_drop) || short_chirps !== CW'(m_short) || frames_out !== CW'(m_out)) begin
                errors++;
                if (errors < 20) $display("FAIL rand_counters@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                    dropped_chirps, short_chirps, frames_out, m_drop, m_short, CW'(m_out));
            end
            if (m_cnt > 0) begin
                bad = 0;
                for (int i = 0; i < FL; i++) if (frame_data[i] !== m_fr[m_head][i]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    if (errors < 20) $display("FAIL rand_data@%0d: %0d words wrong, want 0", c, bad);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single();
        test_pingpong();
        test_short();
        test_free_same_cycle();
        test_reset_mid();
        test_streaming();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached, got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/radar_chirp_framer.md
# radar_chirp_framer

Collects the streaming ADC samples of one receive channel into complete chirp frames of FRAME_LEN samples. Hands each frame, as a parallel array, to the range FFT stage (the Range_Processor `data_in [0:127]` input). The block sits directly upstream of the range processor. It uses ping-pong double buffering so that one chirp can fill while the previous one waits for, or is held during, consumption. It detects short chirps and drops chirps when both buffers are full, counting both events.

## Interface
Parameters:
- SAMPLE_WIDTH, 16, ADC sample width (two's complement, passed through untouched)
- FRAME_LEN, 128, samples per chirp frame; power of two, ≥ 4
- CNT_WIDTH, 16, width of the error/statistic counters

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- sample_in  in  SAMPLE_WIDTH  ADC sample
- sample_valid  in  1  sample_in is valid this cycle
- chirp_start  in  1  qualifies the valid sample as the first sample of a chirp; ignored when sample_valid=0
- frame_data  out  SAMPLE_WIDTH × [0:FRAME_LEN-1]  contents of the current read bank; meaningful only while frame_valid=1
- frame_valid  out  1  read bank holds a complete frame
- frame_ready  in  1  consumer accepts the frame; the transfer occurs when frame_valid && frame_ready
- overflow  out  1  sticky; set when any chirp is dropped; cleared only by reset
- dropped_chirps  out  CNT_WIDTH  chirps discarded because no bank was free; saturating
- short_chirps  out  CNT_WIDTH  chirps aborted by an early chirp_start; saturating
- frames_out  out  CNT_WIDTH  completed handshakes; wraps modulo 2^CNT_WIDTH

## Operation
- Two banks, B0 and B1, each FRAME_LEN × SAMPLE_WIDTH. Each bank has a registered status flag `full`.
- Pointers: `wr_bank` is the bank being filled; `rd_bank` is the bank presented on frame_data.
- Write FSM states:
  - WAIT: valid samples without chirp_start are ignored. A valid sample with chirp_start does one of two things:
    - If `full[wr_bank]`=0: write the sample to index 0, set wr_idx=1, go to FILL.
    - If `full[wr_bank]`=1: increment dropped_chirps, set overflow, go to DROP.
  - FILL: each valid sample writes bank[wr_idx] and increments wr_idx.
    - On the sample written at index FRAME_LEN-1: set `full[wr_bank]`, toggle wr_bank, go to WAIT.
    - A valid sample with chirp_start at wr_idx ≠ 0 aborts the partial frame and increments short_chirps. The sample is then treated as a new chirp start in the same bank: written at index 0, wr_idx=1, stay in FILL.
  - DROP: valid samples are discarded. A valid sample with chirp_start re-evaluates exactly as in WAIT.
- Bank status is evaluated using the registered `full` flags. A bank freed by a handshake in cycle N is writable from cycle N+1. A chirp_start in cycle N that finds the bank full is therefore dropped.
- Read side:
  - frame_valid = `full[rd_bank]`.
  - On handshake: clear `full[rd_bank]`, toggle rd_bank, increment frames_out.
  - Frames leave in the same order they completed; no frame is ever overwritten while full.
- Simultaneous completion and handshake in the same cycle is legal. The handshake frees rd_bank while the write side sets the other bank full; both updates take effect.
- Saturating counters hold at all-ones.

## Timing
- Reset values:
  - frame_valid=0, overflow=0, all counters=0.
  - Both `full`=0; wr_bank=rd_bank=B0; write FSM in WAIT.
  - frame_data is undefined (bank RAM is not reset).
- Latency: the last sample (index FRAME_LEN-1) is accepted in cycle N; frame_valid=1 in cycle N+1, with frame_data stable.
- frame_data and frame_valid hold steady until the handshake. frame_data changes only at a handshake (rd_bank toggle); frame_valid drops in the cycle after the handshake unless the other bank is full.
- Back-to-back: with frame_ready tied high, frames_out increments once per completed chirp. No drops occur at any sample rate up to one sample per cycle.
- Reset mid-fill or mid-hold discards all data and returns to WAIT. The partial frame produces no output and increments no counter.

## Test plan
- Single chirp, frame_ready=0: chirp_start + 128 consecutive samples 0..127 → frame_valid rises 1 cycle after the sample 127 → frame_data[i]=i. Raise frame_ready one cycle → frames_out=1, frame_valid=0 the following cycle.
- Ping-pong hold: two full chirps (A: 0x1000+i, B: 0x2000+i), frame_ready=0 → both banks full. A third chirp_start → dropped_chirps=1, overflow=1. Then 3 handshakes → only A then B delivered in order, frames_out=2.
- Short chirp: chirp_start, 50 samples, then chirp_start + 128 samples of 0x0AAA → short_chirps=1; the delivered frame is all 0x0AAA.
- Free-same-cycle: both banks full; handshake and chirp_start in the same cycle → chirp dropped (dropped_chirps=1). A chirp_start one cycle later is accepted and completes normally.
- Reset at sample 64 of a chirp → all outputs return to reset values immediately. A subsequent full chirp is delivered correctly, with frames_out=1.
- Streaming: 10 chirps back-to-back with frame_ready=1 and no sample gaps → frames_out=10, overflow=0, dropped_chirps=0.
